// File: rtl/image_stream_reader.sv
// image_stream_reader
//   Reads a burst of wordCount words starting at baseAddress from a dual-port
//   memory (two words per cycle) and presents them as a two-lane stream with
//   valid/ready handshaking. Read data arrives one cycle after the address is
//   presented and lands in a 2-entry FIFO of word pairs, so no read is lost
//   while the consumer stalls.
//
// Ports
//   clk, reset             clock, asynchronous active-high reset
//   start                  one-cycle burst request (sampled only when idle)
//   baseAddress, wordCount burst first address / length, sampled with start
//   address, addressB      port A / port B read addresses
//   writeEnable(B)         always 0
//   memOut, memOutB        port A / port B read data
//   outData, outDataB      lane A / lane B stream data
//   outValid, outValidB    beat valid / lane B holds a word in this beat
//   outReady               downstream accepts the beat
//   busy, done, error      burst active / completion pulse / range error
module image_stream_reader #(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 16,
  parameter int MEM_WORDS = 49152
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] baseAddress,
  input  logic [ADDR_W-1:0] wordCount,
  output logic [ADDR_W-1:0] address,
  output logic [ADDR_W-1:0] addressB,
  output logic              writeEnable,
  output logic              writeEnableB,
  input  logic [DATA_W-1:0] memOut,
  input  logic [DATA_W-1:0] memOutB,
  output logic [DATA_W-1:0] outData,
  output logic [DATA_W-1:0] outDataB,
  output logic              outValid,
  output logic              outValidB,
  input  logic              outReady,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [ADDR_W-1:0] r_next;
  logic [ADDR_W-1:0] r_rem;
  logic [ADDR_W-1:0] r_addr_q;
  logic [ADDR_W-1:0] r_addrb_q;
  logic              r_inflight;
  logic              r_infl_b;

  logic [DATA_W-1:0] r_fifo_a  [2];
  logic [DATA_W-1:0] r_fifo_b  [2];
  logic              r_fifo_vb [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;

  logic              r_done;
  logic              r_error;

  logic              w_pop;
  logic [2:0]        w_occ;
  logic              w_issue;
  logic              w_lane_b;
  logic              w_last;
  logic [ADDR_W-1:0] w_step;
  logic              w_range_err;
  logic              w_zero;
  logic              w_accept;

  assign w_pop       = (r_count != 2'd0) && outReady;
  // Credit counts the slot freed by this cycle's pop; without it the pipe
  // alternates issue/stall and only reaches half rate.
  assign w_occ       = {1'b0, r_count} + {2'b0, r_inflight} - {2'b0, w_pop};
  assign w_issue     = (r_state == S_RUN) && (w_occ < 3'd2);
  assign w_lane_b    = (r_rem > ADDR_W'(1));
  assign w_last      = (r_rem <= ADDR_W'(2));
  assign w_step      = w_lane_b ? ADDR_W'(2) : ADDR_W'(1);
  assign w_range_err = ({1'b0, baseAddress} + {1'b0, wordCount}) > MEM_LIMIT;
  assign w_zero      = (wordCount == '0);
  assign w_accept    = (r_state == S_IDLE) && start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start && !w_zero && !w_range_err) w_state_nxt = S_RUN;
      S_RUN:   if (w_issue && w_last) w_state_nxt = S_DRAIN;
      S_DRAIN: if ((r_count == 2'd0) && !r_inflight) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Burst bookkeeping, issue tracking and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_next     <= '0;
      r_rem      <= '0;
      r_addr_q   <= '0;
      r_addrb_q  <= '0;
      r_inflight <= 1'b0;
      r_infl_b   <= 1'b0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_count    <= 2'd0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_next  <= baseAddress;
        r_rem   <= wordCount;
        r_error <= !w_zero && w_range_err;
        if (w_zero || w_range_err) r_done <= 1'b1;
      end
      if ((r_state == S_DRAIN) && (w_state_nxt == S_IDLE)) r_done <= 1'b1;

      r_inflight <= w_issue;
      r_infl_b   <= w_lane_b;
      if (w_issue) begin
        r_addr_q  <= r_next;
        r_addrb_q <= r_next + ADDR_W'(1);
        r_next    <= r_next + w_step;
        r_rem     <= r_rem - w_step;
      end

      if (r_inflight) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)      r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end

  // FIFO storage needs no reset: r_count gates every read of it.
  always_ff @(posedge clk) begin
    if (r_inflight) begin
      r_fifo_a[r_wr_ptr]  <= memOut;
      r_fifo_b[r_wr_ptr]  <= memOutB;
      r_fifo_vb[r_wr_ptr] <= r_infl_b;
    end
  end

  // Addresses are presented combinationally in the issue cycle so the
  // synchronous memory returns data on the following cycle; otherwise the
  // last issued value is held.
  assign address      = w_issue ? r_next : r_addr_q;
  assign addressB     = w_issue ? (r_next + ADDR_W'(1)) : r_addrb_q;
  assign writeEnable  = 1'b0;
  assign writeEnableB = 1'b0;

  assign outValid  = (r_count != 2'd0);
  assign outData   = r_fifo_a[r_rd_ptr];
  assign outDataB  = r_fifo_b[r_rd_ptr];
  assign outValidB = outValid && r_fifo_vb[r_rd_ptr];

  assign busy  = (r_state != S_IDLE);
  assign done  = r_done;
  assign error = r_error;

endmodule
